regfile_pc: RTL and testbench

Architectural state block for the single-cycle processor: holds the program counter and the ARM register file R0–R14, and presents R15 reads as PC+8. It sits directly downstream of the control unit. It consumes `PCSrc`, `RegWrite` and `RegSrc` together with the fetched `Instr`. It supplies `RD1`/`RD2` to the ALU/immediate path and `PC` to instruction memory. `Result` (ALU or memory output) returns here as write data and as the branch/PC-write target.

---
 rtl/regfile_pc.sv | 91 +++++++++
 tb/tb_regfile_pc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_pc.sv
// Architectural state for the single-cycle core: program counter plus R0-R14.
// Reads of register 15 return PC+8; reads are combinational, writes and PC updates happen on clk.
module regfile_pc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] RESET_REG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [1:0]  RegSrc,
  input  logic        RegWrite,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4
);

  localparam int NUM_REGS = 15;

  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [3:0]  wa3;
  logic [31:0] rf_reg [0:NUM_REGS-1];
  logic [NUM_REGS-1:0] we;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic [31:0] rd1_next;
  logic [31:0] rd2_next;

  assign ra1 = RegSrc[0] ? 4'd15 : Instr[19:16];
  assign ra2 = RegSrc[1] ? Instr[15:12] : Instr[3:0];
  assign wa3 = Instr[15:12];

  // One-hot write enables; address 15 matches no entry, so PC writes come only via PCSrc.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
      assign we[gi] = RegWrite && (wa3 == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_reg[i] <= RESET_REG;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we[i]) begin
          rf_reg[i] <= Result;
        end
      end
    end
  end

  assign pc_plus4 = pc_reg + 32'd4;
  assign pc_plus8 = pc_reg + 32'd8;
  assign pc_next  = PCSrc ? {Result[31:2], 2'b00} : pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // No write bypass: a same-cycle read of the written register sees the old value.
  always_comb begin
    rd1_next = pc_plus8;
    rd2_next = pc_plus8;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ra1 == 4'(i)) begin
        rd1_next = rf_reg[i];
      end
      if (ra2 == 4'(i)) begin
        rd2_next = rf_reg[i];
      end
    end
  end

  assign RD1     = rd1_next;
  assign RD2     = rd2_next;
  assign PC      = pc_reg;
  assign PCPlus4 = pc_plus4;

endmodule

// File: tb/tb_regfile_pc.sv
// Self-checking bench for regfile_pc: directed scenarios plus randomized traffic
// compared against an array-based architectural model.
module tb_regfile_pc;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic        PCSrc;
  logic [31:0] Result;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] PC;
  logic [31:0] PCPlus4;

  int errors = 0;
  int checks = 0;

  // Architectural model: plain array of registers and a PC.
  logic [31:0] m_r [0:15];
  logic [31:0] m_pc;

  regfile_pc dut (
    .clk      (clk),
    .reset    (reset),
    .Instr    (Instr),
    .RegSrc   (RegSrc),
    .RegWrite (RegWrite),
    .PCSrc    (PCSrc),
    .Result   (Result),
    .RD1      (RD1),
    .RD2      (RD2),
    .PC       (PC),
    .PCPlus4  (PCPlus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    return (a == 4'd15) ? (m_pc + 32'd8) : m_r[a];
  endfunction

  function automatic logic [3:0] m_ra1();
    return RegSrc[0] ? 4'd15 : Instr[19:16];
  endfunction

  function automatic logic [3:0] m_ra2();
    return RegSrc[1] ? Instr[15:12] : Instr[3:0];
  endfunction

  // One clock edge: update the model from the inputs the DUT samples, then step past the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_pc = 32'h0000_0000;
      for (int i = 0; i < 15; i++) m_r[i] = 32'h0000_0000;
    end else begin
      if (RegWrite && Instr[15:12] != 4'd15) m_r[Instr[15:12]] = Result;
      m_pc = PCSrc ? (Result & 32'hFFFF_FFFC) : (m_pc + 32'd4);
    end
    #1;
  endtask

  task automatic idle_inputs();
    RegWrite = 1'b0;
    PCSrc    = 1'b0;
    RegSrc   = 2'b00;
    Instr    = 32'h0;
    Result   = $urandom;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    Instr = 32'h0003_0000;
    RegSrc = 2'b00;
    #1;
    checks++;
    if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc actual=%h required=%h", PC, 32'h0); end
    checks++;
    if (PCPlus4 !== 32'h4) begin errors++; $display("FAIL reset_pcplus4 actual=%h required=%h", PCPlus4, 32'h4); end
    checks++;
    if (RD1 !== 32'h0) begin errors++; $display("FAIL reset_rd1_r3 actual=%h required=%h", RD1, 32'h0); end
    RegSrc = 2'b10;
    Instr  = 32'h0000_F000;
    #1;
    checks++;
    if (RD2 !== 32'h8) begin errors++; $display("FAIL reset_rd2_r15 actual=%h required=%h", RD2, 32'h8); end
    $display("test_reset: PC=%h PCPlus4=%h RD2(R15)=%h", PC, PCPlus4, RD2);
  endtask

  task automatic test_fetch();
    logic [31:0] exp_pc;
    idle_inputs();
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      checks++;
      if (PC !== exp_pc) begin errors++; $display("FAIL fetch_pc actual=%h required=%h", PC, exp_pc); end
      $display("test_fetch: PC=%h", PC);
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    Instr    = 32'hE280_1005;
    RegWrite = 1'b1;
    Result   = 32'h5;
    RegSrc   = 2'b10;
    #1;
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("FAIL write_same_cycle actual=%h required=%h", RD2, 32'h0); end
    tick();
    RegWrite = 1'b0;
    RegSrc   = 2'b00;
    Instr    = 32'h0000_0001;
    #1;
    checks++;
    if (RD2 !== 32'h5) begin errors++; $display("FAIL write_next_cycle actual=%h required=%h", RD2, 32'h5); end
    $display("test_write_read: R1 after write=%h", RD2);
  endtask

  task automatic test_r15();
    idle_inputs();
    PCSrc  = 1'b1;
    Result = 32'h0000_0010;
    tick();
    PCSrc  = 1'b0;
    RegSrc = 2'b01;
    #1;
    checks++;
    if (RD1 !== 32'h18) begin errors++; $display("FAIL r15_rd1 actual=%h required=%h", RD1, 32'h18); end
    RegSrc = 2'b10;
    Instr  = 32'h0000_F000;
    #1;
    checks++;
    if (RD2 !== 32'h18) begin errors++; $display("FAIL r15_rd2 actual=%h required=%h", RD2, 32'h18); end
    $display("test_r15: PC=%h RD1=%h RD2=%h", PC, RD1, RD2);
  endtask

  task automatic test_branch();
    idle_inputs();
    PCSrc  = 1'b1;
    Result = 32'h0000_0103;
    tick();
    checks++;
    if (PC !== 32'h100) begin errors++; $display("FAIL branch_pc actual=%h required=%h", PC, 32'h100); end
    $display("test_branch: PC=%h", PC);
    PCSrc    = 1'b0;
    RegWrite = 1'b1;
    Instr    = 32'h0000_F000;
    Result   = 32'hA5A5_5A5A;
    tick();
    RegWrite = 1'b0;
    checks++;
    if (PC !== 32'h104) begin errors++; $display("FAIL wa15_pc actual=%h required=%h", PC, 32'h104); end
    RegSrc = 2'b00;
    for (int i = 0; i < 15; i++) begin
      Instr = i;
      #1;
      checks++;
      if (RD2 !== m_r[i]) begin errors++; $display("FAIL wa15_reg%0d actual=%h required=%h", i, RD2, m_r[i]); end
    end
    $display("test_branch: WA3=15 write left R0-R14 unchanged, PC=%h", PC);
  endtask

  task automatic test_reset_priority();
    idle_inputs();
    RegWrite = 1'b1;
    Instr    = 32'h0000_2000;
    Result   = 32'h0000_1234;
    tick();
    reset    = 1'b1;
    RegWrite = 1'b1;
    PCSrc    = 1'b1;
    Result   = 32'hDEAD_BEEF;
    tick();
    reset    = 1'b0;
    RegWrite = 1'b0;
    PCSrc    = 1'b0;
    Instr    = 32'h0000_0002;
    RegSrc   = 2'b00;
    #1;
    checks++;
    if (RD2 !== 32'h0) begin errors++; $display("FAIL rstprio_r2 actual=%h required=%h", RD2, 32'h0); end
    checks++;
    if (PC !== 32'h0) begin errors++; $display("FAIL rstprio_pc actual=%h required=%h", PC, 32'h0); end
    $display("test_reset_priority: R2=%h PC=%h", RD2, PC);
  endtask

  task automatic test_wrap();
    idle_inputs();
    PCSrc  = 1'b1;
    Result = 32'hFFFF_FFFE;
    tick();
    checks++;
    if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup actual=%h required=%h", PC, 32'hFFFF_FFFC); end
    checks++;
    if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4 actual=%h required=%h", PCPlus4, 32'h0); end
    PCSrc = 1'b0;
    tick();
    RegSrc = 2'b01;
    #1;
    checks++;
    if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc actual=%h required=%h", PC, 32'h0); end
    checks++;
    if (RD1 !== 32'h8) begin errors++; $display("FAIL wrap_r15 actual=%h required=%h", RD1, 32'h8); end
    $display("test_wrap: PC=%h RD1(R15)=%h", PC, RD1);
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 200; n++) begin
      Instr    = $urandom;
      RegSrc   = 2'($urandom_range(0, 3));
      RegWrite = ($urandom_range(0, 2) != 0);
      PCSrc    = ($urandom_range(0, 7) == 0);
      Result   = $urandom;
      reset    = ($urandom_range(0, 49) == 0);
      #1;
      e1 = m_read(m_ra1());
      e2 = m_read(m_ra2());
      checks++;
      if (RD1 !== e1) begin errors++; $display("FAIL rand_rd1 actual=%h required=%h", RD1, e1); end
      checks++;
      if (RD2 !== e2) begin errors++; $display("FAIL rand_rd2 actual=%h required=%h", RD2, e2); end
      checks++;
      if (PC !== m_pc) begin errors++; $display("FAIL rand_pc actual=%h required=%h", PC, m_pc); end
      checks++;
      if (PCPlus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rand_pcplus4 actual=%h required=%h", PCPlus4, m_pc + 32'd4); end
      $display("rand %0d: instr=%h regsrc=%b we=%b pcsrc=%b rst=%b result=%h pc=%h rd1=%h rd2=%h",
               n, Instr, RegSrc, RegWrite, PCSrc, reset, Result, PC, RD1, RD2);
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    Instr    = 32'h0;
    RegSrc   = 2'b00;
    RegWrite = 1'b0;
    PCSrc    = 1'b0;
    Result   = 32'h0;
    m_pc     = 32'h0;
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    test_reset();
    test_fetch();
    test_write_read();
    test_r15();
    test_branch();
    test_reset_priority();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
